mem_access: RTL
===============

Name: mem_access

Overview:
- Memory-access pipeline stage between execute and writeback.
- Takes one EX/MEM bundle, drives the data-bus request/response handshake for loads and stores, and generates byte strobes and lane-replicated store data.
- Registers the MEM/WB bundle that writeback consumes: raw 64-bit read data, addr_low, mem_size, if_mem_zero and the load-done flag `sig`.
- Stalls upstream while a bus transaction is outstanding.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data bus / register width (fixed 64; strobe width DATA_W/8)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  EX/MEM bundle valid
- in_ready  out  1  stage can accept the bundle
- in_mem_read  in  1  load
- in_mem_write  in  1  store
- in_mem_size  in  msize_t  access size
- in_if_mem_zero  in  1  unsigned load
- in_addr  in  ADDR_W  effective address
- in_store_data  in  DATA_W  rs2 value
- in_alu_result  in  DATA_W  non-load result
- in_rd  in  5  destination register
- in_reg_write  in  1  register write enable
- in_mem_to_reg  in  1  select load data
- dreq_valid  out  1  bus request valid
- dreq_addr  out  ADDR_W  request address
- dreq_size  out  msize_t  request size
- dreq_strobe  out  8  byte write enables (0 for loads)
- dreq_data  out  DATA_W  lane-replicated store data
- dresp_addr_ok  in  1  address accepted
- dresp_data_ok  in  1  data phase complete
- dresp_data  in  DATA_W  load data
- wb_valid  out  1  MEM/WB bundle valid (one-cycle pulse per bundle)
- wb_read_data  out  DATA_W  raw dresp_data
- wb_addr_low  out  3  in_addr[2:0]
- wb_mem_size  out  msize_t
- wb_if_mem_zero  out  1
- wb_write_data  out  DATA_W  in_alu_result
- wb_rd  out  5
- wb_reg_write  out  1
- wb_mem_to_reg  out  1
- wb_sig  out  1  load data valid
- wb_misalign  out  1  misaligned access detected

Behaviour:
- **Reset** (reset=0, asynchronous):
  - State goes to IDLE.
  - All wb_* outputs are 0.
  - dreq_valid is 0.
  - in_ready is 1 after reset release.
- **States:**
  - IDLE, REQ, WAIT.
  - in_ready = (state==IDLE).
  - A bundle is accepted on in_valid && in_ready.
- **Non-memory bundle** (neither mem_read nor mem_write):
  - Registered to wb_* on acceptance; wb_valid=1 the next cycle (latency 1).
  - wb_sig=0; state stays IDLE.
- **Misalignment:** addr[0]≠0 for MSIZE2, addr[1:0]≠0 for MSIZE4, addr[2:0]≠0 for MSIZE8.
  - No bus request is issued.
  - Next cycle: wb_valid=1, wb_misalign=1, wb_reg_write=0, wb_sig=0.
- **Aligned memory bundle:**
  - Fields are latched; next state REQ.
  - REQ: dreq_valid=1, with addr/size/strobe/data driven from latched values and stable until dresp_addr_ok.
  - REQ with addr_ok && !data_ok → WAIT.
  - REQ with addr_ok && data_ok → complete.
  - WAIT with data_ok → complete.
  - data_ok while in REQ without addr_ok is ignored.
- **Complete:**
  - Register the MEM/WB bundle; wb_valid=1 next cycle; return to IDLE.
  - Minimum latency: accept at T, request at T+1, wb_valid at T+2.
- **wb_read_data:** dresp_data for loads; 0 for stores.
- **wb_sig:**
  - 1 for completed loads.
  - 0 for stores, so writeback suppresses the regwrite of mem_to_reg bundles that lack load data.
- **wb_reg_write:** in_reg_write for loads and non-memory bundles; 0 for stores.
- **Strobes (stores):**
  - MSIZE1: 8'h01<<addr[2:0]
  - MSIZE2: 8'h03<<{addr[2:1],1'b0}
  - MSIZE4: 8'h0F<<{addr[2],2'b00}
  - MSIZE8: 8'hFF
- **Store data:** low byte ×8, low half ×4, low word ×2, or full dword, according to size.
- **Loads:** dreq_strobe=0.
- **Bubbles:** wb_valid is 0 on every cycle without completion.
- **Reset mid-transaction:** the request is abandoned; a late dresp after reset is ignored (state IDLE).

Decomposition:
- common package:
  - msize_t (MSIZE1=0, MSIZE2=1, MSIZE4=2, MSIZE8=3).
  - mem_state_t {IDLE, REQ, WAIT}.
  - Constant MEM_STRB_W=8.
- Sub-module mem_strobe_gen (combinational):
  - Inputs: size, addr[2:0], store data.
  - Outputs: strobe, replicated data, misalign.

Test Plan:
- Reset low mid-REQ → dreq_valid=0 and wb_valid=0 immediately; in_ready=1 after release; dresp_data_ok=1 next cycle produces no wb_valid.
- ADD-type bundle (alu_result=0x1234, rd=5, reg_write=1) → wb_valid at T+1 with wb_write_data=0x1234, wb_rd=5, wb_sig=0, in_ready held 1.
- SB, addr=0x1003, store_data=0xAB:
  - → dreq_strobe=8'h08, dreq_data=0xABABABABABABABAB.
  - addr_ok+data_ok in the first REQ cycle → wb_valid at T+2, wb_reg_write=0.
- LW, addr=0x2004, addr_ok at cycle 3 of REQ, data_ok 2 cycles later with data 0x80000000_00000000:
  - → dreq fields stable throughout; in_ready=0 until completion.
  - → wb_read_data equal to the response, wb_addr_low=3'b100, wb_sig=1.
- LD, addr=0x3002 → no dreq_valid; wb_misalign=1, wb_reg_write=0 at T+1.
- SH, addr=0x0006, data 0xBEEF → strobe 8'hC0, data 0xBEEFBEEFBEEFBEEF.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-access stage.
package mem_access_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    localparam int unsigned MEM_STRB_W = 8;

endpackage

// File: rtl/mem_access_strobe_gen.sv
// Byte-strobe, lane-replicated store data and alignment check for one access.
module mem_strobe_gen
    import mem_access_pkg::*;
(
    input  msize_t                  size_i,
    input  logic [2:0]              addr_i,
    input  logic [63:0]             data_i,
    output logic [MEM_STRB_W-1:0]   strobe_o,
    output logic [63:0]             data_o,
    output logic                    misalign_o
);

    always_comb begin
        strobe_o   = '0;
        data_o     = '0;
        misalign_o = 1'b0;
        case (size_i)
            MSIZE1: begin
                strobe_o = 8'h01 << addr_i;
                data_o   = {8{data_i[7:0]}};
            end
            MSIZE2: begin
                strobe_o   = 8'h03 << {addr_i[2:1], 1'b0};
                data_o     = {4{data_i[15:0]}};
                misalign_o = addr_i[0];
            end
            MSIZE4: begin
                strobe_o   = 8'h0F << {addr_i[2], 2'b00};
                data_o     = {2{data_i[31:0]}};
                misalign_o = |addr_i[1:0];
            end
            MSIZE8: begin
                strobe_o   = 8'hFF;
                data_o     = data_i;
                misalign_o = |addr_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: bus request/response handshake and MEM/WB register.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    input  msize_t                in_mem_size,
    input  logic                  in_if_mem_zero,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [DATA_W-1:0]     in_store_data,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [4:0]            in_rd,
    input  logic                  in_reg_write,
    input  logic                  in_mem_to_reg,
    output logic                  dreq_valid,
    output logic [ADDR_W-1:0]     dreq_addr,
    output msize_t                dreq_size,
    output logic [MEM_STRB_W-1:0] dreq_strobe,
    output logic [DATA_W-1:0]     dreq_data,
    input  logic                  dresp_addr_ok,
    input  logic                  dresp_data_ok,
    input  logic [DATA_W-1:0]     dresp_data,
    output logic                  wb_valid,
    output logic [DATA_W-1:0]     wb_read_data,
    output logic [2:0]            wb_addr_low,
    output msize_t                wb_mem_size,
    output logic                  wb_if_mem_zero,
    output logic [DATA_W-1:0]     wb_write_data,
    output logic [4:0]            wb_rd,
    output logic                  wb_reg_write,
    output logic                  wb_mem_to_reg,
    output logic                  wb_sig,
    output logic                  wb_misalign
);

    mem_state_t state_q, state_d;

    logic [ADDR_W-1:0]     addr_q;
    msize_t                size_q;
    logic [MEM_STRB_W-1:0] strobe_q;
    logic [DATA_W-1:0]     sdata_q, alu_q;
    logic [4:0]            rd_q;
    logic                  load_q, zero_q, regwr_q, m2r_q;

    logic [MEM_STRB_W-1:0] gen_strobe;
    logic [DATA_W-1:0]     gen_data;
    logic                  gen_misalign;
    logic                  accept, is_mem, misalign, complete;

    mem_strobe_gen u_strobe_gen (
        .size_i     (in_mem_size),
        .addr_i     (in_addr[2:0]),
        .data_i     (in_store_data),
        .strobe_o   (gen_strobe),
        .data_o     (gen_data),
        .misalign_o (gen_misalign)
    );

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;
    assign is_mem   = in_mem_read || in_mem_write;
    assign misalign = is_mem && gen_misalign;

    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        case (state_q)
            IDLE: if (accept && is_mem && !misalign) state_d = REQ;
            REQ: begin
                // data_ok is only meaningful once the address has been taken
                if (dresp_addr_ok) begin
                    if (dresp_data_ok) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dresp_data_ok) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= '0;
            size_q   <= MSIZE1;
            strobe_q <= '0;
            sdata_q  <= '0;
            alu_q    <= '0;
            rd_q     <= '0;
            load_q   <= 1'b0;
            zero_q   <= 1'b0;
            regwr_q  <= 1'b0;
            m2r_q    <= 1'b0;
        end else if (accept && is_mem) begin
            addr_q   <= in_addr;
            size_q   <= in_mem_size;
            strobe_q <= in_mem_read ? '0 : gen_strobe;
            sdata_q  <= gen_data;
            alu_q    <= in_alu_result;
            rd_q     <= in_rd;
            load_q   <= in_mem_read;
            zero_q   <= in_if_mem_zero;
            regwr_q  <= in_reg_write;
            m2r_q    <= in_mem_to_reg;
        end
    end

    assign dreq_valid  = (state_q == REQ);
    assign dreq_addr   = addr_q;
    assign dreq_size   = size_q;
    assign dreq_strobe = strobe_q;
    assign dreq_data   = sdata_q;

    // Non-memory and misaligned bundles bypass the bus and retire straight from the input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid       <= 1'b0;
            wb_read_data   <= '0;
            wb_addr_low    <= '0;
            wb_mem_size    <= MSIZE1;
            wb_if_mem_zero <= 1'b0;
            wb_write_data  <= '0;
            wb_rd          <= '0;
            wb_reg_write   <= 1'b0;
            wb_mem_to_reg  <= 1'b0;
            wb_sig         <= 1'b0;
            wb_misalign    <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            if (accept && (!is_mem || misalign)) begin
                wb_valid       <= 1'b1;
                wb_read_data   <= '0;
                wb_addr_low    <= in_addr[2:0];
                wb_mem_size    <= in_mem_size;
                wb_if_mem_zero <= in_if_mem_zero;
                wb_write_data  <= in_alu_result;
                wb_rd          <= in_rd;
                wb_reg_write   <= in_reg_write && !misalign;
                wb_mem_to_reg  <= in_mem_to_reg;
                wb_sig         <= 1'b0;
                wb_misalign    <= misalign;
            end else if (complete) begin
                wb_valid       <= 1'b1;
                wb_read_data   <= load_q ? dresp_data : '0;
                wb_addr_low    <= addr_q[2:0];
                wb_mem_size    <= size_q;
                wb_if_mem_zero <= zero_q;
                wb_write_data  <= alu_q;
                wb_rd          <= rd_q;
                wb_reg_write   <= load_q && regwr_q;
                wb_mem_to_reg  <= m2r_q;
                wb_sig         <= load_q;
                wb_misalign    <= 1'b0;
            end
        end
    end

endmodule
